instr_encoder: RTL and testbench

Program-loader encoder for the single-cycle MIPS core: it packs field-level instruction descriptors into 32-bit MIPS words and streams them into instruction memory. It covers the subset the control decoder recognises: R-type, LW, SW, ADDI, BEQ and J. It sits between the test/boot loader front end and the instruction-memory write port. It provides a valid/ready input handshake, a 2-entry output buffer, and memory-side backpressure.

---
 rtl/instr_encoder.sv | 147 ++++++++++++++
 tb/tb_instr_encoder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs MIPS instruction descriptors into 32-bit words and streams them into
// instruction memory through a 2-entry buffer with memory-side backpressure.
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [ADDR_W+1:0] CAPACITY = {2'b01, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [31:0]       mem_q [2];
  logic [31:0]       mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              err_ill_q, err_ill_d;
  logic              err_ovf_q, err_ovf_d;

  logic              accept, legal, mem_full, push, pop, active;
  logic [ADDR_W+1:0] fill;
  logic [31:0]       enc_word;

  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (in_class)
      3'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      3'd1:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
      3'd2:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
      3'd3:    enc_word = {6'b001000, in_rs, in_rt, in_imm};
      3'd4:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
      3'd5:    enc_word = {6'b000010, in_target};
      default: legal    = 1'b0;
    endcase
  end

  always_comb begin
    active     = (state_q == S_RUN) || (state_q == S_DRAIN);
    in_ready   = (state_q == S_RUN) && (cnt_q != 2'd2);
    accept     = in_valid && in_ready;
    // Words already written plus words still buffered count against capacity.
    fill       = {1'b0, wc_q} + {{ADDR_W{1'b0}}, cnt_q};
    mem_full   = (fill == CAPACITY);
    push       = accept && legal && !mem_full;
    imem_we    = active && (cnt_q != 2'd0);
    pop        = imem_we && imem_ready;
    imem_wdata = imem_we ? mem_q[rd_ptr_q] : '0;
    imem_addr  = BASE_ADDR + wc_q[ADDR_W-1:0];
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    err_illegal  = err_ill_q;
    err_overflow = err_ovf_q;
    word_count   = wc_q;
  end

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    wc_d      = wc_q;
    err_ill_d = err_ill_q;
    err_ovf_d = err_ovf_q;

    if (push) begin
      mem_d[wr_ptr_q] = enc_word;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      wc_d     = wc_q + 1'b1;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    if (accept && !legal)            err_ill_d = 1'b1;
    if (accept && legal && mem_full) err_ovf_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          wc_d      = '0;
          err_ill_d = 1'b0;
          err_ovf_d = 1'b0;
          cnt_d     = '0;
          rd_ptr_d  = 1'b0;
          wr_ptr_d  = 1'b0;
        end
      end
      S_RUN:   if (finish) state_d = S_DRAIN;
      // Looking at next occupancy lets done land one cycle after the last pop.
      S_DRAIN: if (cnt_d == 2'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= '0;
      wc_q      <= '0;
      err_ill_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      wc_q      <= wc_d;
      err_ill_q <= err_ill_d;
      err_ovf_q <= err_ovf_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: an 8-bit-address instance for encoding and
// control corners, plus a 2-bit-address instance sharing inputs for overflow.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, finish = 1'b0, in_valid = 1'b0, imem_ready = 1'b1;
  logic [2:0]  in_class = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;

  logic        in_ready, imem_we, busy, done, err_illegal, err_overflow;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  word_count;

  logic        in_ready2, imem_we2, busy2, done2, err_illegal2, err_overflow2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0]  word_count2;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .busy(busy), .done(done),
    .err_illegal(err_illegal), .err_overflow(err_overflow), .word_count(word_count)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready2), .in_class(in_class),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .imem_ready(imem_ready), .busy(busy2), .done(done2),
    .err_illegal(err_illegal2), .err_overflow(err_overflow2), .word_count(word_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tg;
    logic [31:0] exp_w;
  } vec_t;

  vec_t vecs [6];

  int checks = 0;
  int errors = 0;

  logic [7:0]  wa [$];
  logic [31:0] wd [$];
  logic [1:0]  w2a [$];
  logic [31:0] w2d [$];
  int cyc = 0, last_wr_cyc = 0, done_cyc = 0, done_cnt = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (imem_we && imem_ready) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      last_wr_cyc = cyc;
    end
    if (imem_we2 && imem_ready) begin
      w2a.push_back(imem_addr2);
      w2d.push_back(imem_wdata2);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); w2a.delete(); w2d.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tg);
    bit ok;
    in_class = cls; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tg;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready && in_ready2) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("send_ready_timeout", {31'd0, ok}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_addi(input logic [4:0] rt, input logic [15:0] imm);
    send(3'd3, 5'd0, rt, 5'd0, 5'd0, 6'd0, imm, 26'd0);
  endtask

  task automatic end_session();
    bit idle;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy && !busy2) begin
        idle = 1'b1;
        break;
      end
      tick();
    end
    chk("idle_timeout", {31'd0, idle}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_imem_addr"}, {24'd0, imem_addr}, 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err_illegal"}, {31'd0, err_illegal}, 32'd0);
    chk({tag, "_err_overflow"}, {31'd0, err_overflow}, 32'd0);
    chk({tag, "_word_count"}, {23'd0, word_count}, 32'd0);
  endtask

  initial begin
    int d0, acc;
    vecs[0] = '{3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 26'd0,    32'h00221820};
    vecs[1] = '{3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 26'd0,    32'h8D280004};
    vecs[2] = '{3'd2, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 26'd0,    32'hAD280004};
    vecs[3] = '{3'd3, 5'd0, 5'd5, 5'd0, 5'd0, 6'h00, 16'h0007, 26'd0,    32'h20050007};
    vecs[4] = '{3'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'hFFFF, 26'd0,    32'h1022FFFF};
    vecs[5] = '{3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h10,   32'h08000010};

    #2 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Encoding session over the vector table
    clear_log();
    d0 = done_cnt;
    do_start();
    chk("start_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) chk("pre_we", {31'd0, imem_we}, 32'd0);
      send(vecs[k].cls, vecs[k].rs, vecs[k].rt, vecs[k].rd, vecs[k].sh,
           vecs[k].fn, vecs[k].imm, vecs[k].tg);
      if (k == 0) begin
        chk("latency_we", {31'd0, imem_we}, 32'd1);
        chk("latency_wdata", imem_wdata, vecs[0].exp_w);
      end
    end
    end_session();
    chk("enc_nwords", wd.size(), 32'd6);
    for (int k = 0; k < 6 && k < wd.size(); k++) begin
      chk($sformatf("enc_addr%0d", k), {24'd0, wa[k]}, k);
      chk($sformatf("enc_data%0d", k), wd[k], vecs[k].exp_w);
    end
    chk("enc_word_count", {23'd0, word_count}, 32'd6);
    chk("enc_done_pulses", done_cnt - d0, 32'd1);

    // Backpressure: memory stalls for 5 cycles with in_valid held
    clear_log();
    do_start();
    imem_ready = 1'b0;
    acc = 0;
    in_class = 3'd3; in_rs = '0; in_rt = '0; in_imm = 16'd0;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_in_ready_c%0d", c), {31'd0, in_ready}, (c < 2) ? 32'd1 : 32'd0);
      if (c >= 1) begin
        chk($sformatf("bp_we_c%0d", c), {31'd0, imem_we}, 32'd1);
        chk($sformatf("bp_wdata_c%0d", c), imem_wdata, 32'h20000000);
        chk($sformatf("bp_addr_c%0d", c), {24'd0, imem_addr}, 32'd0);
      end
      if (in_ready) acc++;
      tick();
      in_imm = 16'(acc);
    end
    in_valid = 1'b0;
    imem_ready = 1'b1;
    chk("bp_accepts", acc, 32'd2);
    end_session();
    chk("bp_nwords", wd.size(), 32'd2);
    if (wd.size() == 2) begin
      chk("bp_data0", wd[0], 32'h20000000);
      chk("bp_data1", wd[1], 32'h20000001);
      chk("bp_addr1", {24'd0, wa[1]}, 32'd1);
    end

    // Illegal class between two ADDIs
    clear_log();
    do_start();
    send_addi(5'd1, 16'h0011);
    send(3'd6, 5'd3, 5'd3, 5'd3, 5'd3, 6'h3F, 16'hABCD, 26'h3FFFFFF);
    send_addi(5'd2, 16'h0022);
    end_session();
    chk("ill_nwords", wd.size(), 32'd2);
    if (wd.size() == 2) begin
      chk("ill_data0", wd[0], 32'h20010011);
      chk("ill_data1", wd[1], 32'h20020022);
      chk("ill_addr1", {24'd0, wa[1]}, 32'd1);
    end
    chk("ill_flag", {31'd0, err_illegal}, 32'd1);
    chk("ill_ovf_clear", {31'd0, err_overflow}, 32'd0);
    chk("ill_word_count", {23'd0, word_count}, 32'd2);

    // New start clears err_illegal; finish with empty buffer gives done 2 cycles later
    do_start();
    chk("ill_cleared", {31'd0, err_illegal}, 32'd0);
    chk("restart_word_count", {23'd0, word_count}, 32'd0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("drain_done0", {31'd0, done}, 32'd0);
    chk("drain_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("drain_done1", {31'd0, done}, 32'd1);
    tick();
    chk("drain_done_end", {31'd0, done}, 32'd0);
    chk("drain_idle", {31'd0, busy}, 32'd0);

    // Overflow on the 4-word instance
    clear_log();
    do_start();
    for (int k = 0; k < 5; k++) send_addi(5'd0, 16'(k));
    end_session();
    chk("ovf_nwords", w2d.size(), 32'd4);
    for (int k = 0; k < 4 && k < w2d.size(); k++) begin
      chk($sformatf("ovf_addr%0d", k), {30'd0, w2a[k]}, k);
      chk($sformatf("ovf_data%0d", k), w2d[k], 32'h20000000 | k);
    end
    chk("ovf_flag", {31'd0, err_overflow2}, 32'd1);
    chk("ovf_word_count", {29'd0, word_count2}, 32'd4);
    chk("ovf_big_flag", {31'd0, err_overflow}, 32'd0);
    chk("ovf_big_count", {23'd0, word_count}, 32'd5);

    // finish together with an accept; start during DRAIN ignored
    clear_log();
    d0 = done_cnt;
    do_start();
    in_class = 3'd3; in_rs = '0; in_rt = 5'd3; in_imm = 16'h0055;
    in_valid = 1'b1;
    finish = 1'b1;
    tick();
    in_valid = 1'b0;
    finish = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) if (busy) tick();
    tick(); tick();
    chk("fin_idle", {31'd0, busy}, 32'd0);
    chk("fin_nwords", wd.size(), 32'd1);
    if (wd.size() == 1) chk("fin_data", wd[0], 32'h20030055);
    chk("fin_done_pulses", done_cnt - d0, 32'd1);
    chk("fin_write_before_done", {31'd0, (last_wr_cyc < done_cyc)}, 32'd1);

    // Reset while two words are buffered
    clear_log();
    do_start();
    imem_ready = 1'b0;
    send_addi(5'd1, 16'd1);
    send_addi(5'd1, 16'd2);
    chk("rst_pre_full", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    tick();
    rst_n = 1'b1;
    imem_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("rst_no_writes", wd.size(), 32'd0);
    chk("rst_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
